mem_stage_access: RTL
=====================

Name: mem_stage_access

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. Performs the data-memory access for lw/lb/sw over a req/ack memory handshake, stalling upstream stages while the access is outstanding. Drives the MEM/WB register contents directly; the MEM/WB register is internal to this block. Non-memory instructions pass straight through with zero stall.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req stays high without mem_ack before the access is aborted (range 1..255).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
MEM_MemRead  input  1  load in MEM stage
MEM_MemWrite  input  1  store in MEM stage
MEM_WriteData  input  32  store data
MEM_WriteAddr  input  5  destination register
MEM_MemtoReg  input  2  WB mux select, passed through
MEM_RegWrite  input  1  register write enable
MEM_ALU_out  input  32  ALU result / memory byte address
MEM_PC_Plus_4  input  32  link value, passed through
MEM_LwLb  input  1  1 = lb (byte, sign-extended), 0 = lw
mem_req  output  1  memory request, registered
mem_we  output  1  1 = write, valid while mem_req
mem_addr  output  32  word address {MEM_ALU_out[31:2],2'b00}
mem_wdata  output  32  MEM_WriteData, valid while mem_req
mem_ack  input  1  access complete; sampled only while mem_req=1
mem_rdata  input  32  read data, valid with mem_ack
stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM
mem_err  output  1  one-cycle pulse on timeout abort
WB_RegWrite  output  1  MEM/WB register write enable
WB_WriteAddr  output  5  MEM/WB destination register
WB_MemtoReg  output  2  MEM/WB mux select
WB_ALU_out  output  32  MEM/WB ALU result
WB_MemData  output  32  MEM/WB load data, aligned and extended
WB_PC_Plus_4  output  32  MEM/WB link value

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset (synchronous) puts the FSM in IDLE, clears the timeout counter, and drives every output and WB_* register to 0.
- IDLE: if MEM_MemRead|MEM_MemWrite, go to REQ next cycle and set mem_req=1, mem_we=MEM_MemWrite. Otherwise stay in IDLE.
- REQ: mem_req held high with stable addr/wdata/we. On mem_ack: capture mem_rdata, drop mem_req, go to DONE. Minimum access is therefore 2 stall cycles.
- REQ timeout: the counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, drop mem_req, pulse mem_err, force captured data to 0, go to DONE.
- DONE: go to IDLE next cycle. The access is consumed exactly once, even if EX/MEM presents the same instruction again.
- stall = (MEM_MemRead|MEM_MemWrite) && state!=DONE, combinational.
- MEM/WB update every clock:
  - stall=0: load all WB_* fields from MEM_* inputs and the captured/extracted data.
  - stall=1: load a bubble (WB_RegWrite=0, other fields 0).
- Load data:
  - lw: WB_MemData = captured word.
  - lb: byte lane = MEM_ALU_out[1:0], little-endian (lane 0 = bits 7:0), sign-extended to 32 bits.
  - Non-load: WB_MemData = 0.
- Memory read and write both asserted: treated as a write.
- mem_ack outside REQ is ignored. mem_ack on the very cycle the timeout expires is honoured; the data is used and mem_err is not pulsed.
- Reset mid-access (REQ): mem_req drops the next cycle, the FSM returns to IDLE, and the outstanding ack is discarded.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: lw or sw with MEM_ALU_out[1:0]!=0 issues no memory request and no stall, and pulses mem_err for one cycle. The MEM/WB register loads the instruction with WB_RegWrite forced to 0 and WB_MemData=0. lb is never trapped.
- Undefined: the low address bits are ignored for lw/sw; the word-aligned access proceeds normally.

Test Plan:
- ALU instruction (MemRead=MemWrite=0, RegWrite=1, ALU_out=0x1234) → stall stays 0; next cycle WB_ALU_out=0x1234, WB_RegWrite=1; mem_req never asserts.
- lw at ALU_out=0x100, memory acks 1 cycle after req with rdata=0xDEADBEEF → mem_addr=0x100, stall high 2 cycles then low; WB_MemData=0xDEADBEEF, bubble on WB during the stall.
- lb at ALU_out=0x103, rdata=0x80FF_0011 → WB_MemData=0xFFFF_FF80; lb at 0x101 with the same rdata → 0x0000_0000.
- sw of 0xCAFEF00D at 0x200, ack after 3 cycles → mem_we=1, mem_wdata=0xCAFEF00D, exactly one req burst, WB_RegWrite=0.
- lw with no ack, TIMEOUT_CYCLES=4 → mem_req high 4 cycles, then mem_err=1 for one cycle; WB_MemData=0; stall releases the following cycle.
- reset asserted during REQ, then a late ack → mem_req=0 and all WB_* outputs 0 after the reset edge; the late ack causes no WB update. With MISALIGN_TRAP_EN defined, lw at 0x102 → no req, mem_err pulse, WB_RegWrite=0.

Source files
------------

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM pipeline stage with a req/ack data-memory port.
//
// Takes the EX/MEM register outputs and runs the lw/lb/sw data access over
// a registered req/ack handshake. While the access is outstanding, upstream
// stages are stalled and bubbles are fed into the internal MEM/WB register.
// Non-memory instructions pass straight through with no stall.
//
// Parameters:
//   TIMEOUT_CYCLES  REQ cycles without ack before the access is aborted (1..255)
// Optional build macro:
//   MISALIGN_TRAP_EN  trap misaligned lw/sw (no request, mem_err pulse)
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   MEM_*                            EX/MEM register contents
//   mem_req/we/addr/wdata            memory request (registered)
//   mem_ack/rdata                    memory response
//   stall                            hold PC, IF/ID, ID/EX, EX/MEM
//   mem_err                          one-cycle pulse on timeout or trap
//   WB_*                             MEM/WB register contents
module mem_stage_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [31:0] MEM_WriteData,
  input  logic [4:0]  MEM_WriteAddr,
  input  logic [1:0]  MEM_MemtoReg,
  input  logic        MEM_RegWrite,
  input  logic [31:0] MEM_ALU_out,
  input  logic [31:0] MEM_PC_Plus_4,
  input  logic        MEM_LwLb,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        mem_err,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_WriteAddr,
  output logic [1:0]  WB_MemtoReg,
  output logic [31:0] WB_ALU_out,
  output logic [31:0] WB_MemData,
  output logic [31:0] WB_PC_Plus_4
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_waddr_q, wb_waddr_d;
  logic [1:0]  wb_memtoreg_q, wb_memtoreg_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_memdata_q, wb_memdata_d;
  logic [31:0] wb_pc4_q, wb_pc4_d;

  logic        mem_op;
  logic        is_load;
  logic        trap;
  logic [7:0]  lane_byte;
  logic [31:0] load_data;

  assign mem_op  = MEM_MemRead | MEM_MemWrite;
  // Read and write together behaves as a store.
  assign is_load = MEM_MemRead & ~MEM_MemWrite;

`ifdef MISALIGN_TRAP_EN
  assign trap = mem_op && (MEM_MemWrite || !MEM_LwLb) && (MEM_ALU_out[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // DONE releases the stall so the pipeline advances past the finished access.
  assign stall = mem_op && (state_q != StDone) && !trap;

  always_comb begin
    lane_byte = rdata_q[7:0];
    case (MEM_ALU_out[1:0])
      2'd0:    lane_byte = rdata_q[7:0];
      2'd1:    lane_byte = rdata_q[15:8];
      2'd2:    lane_byte = rdata_q[23:16];
      default: lane_byte = rdata_q[31:24];
    endcase
    load_data = MEM_LwLb ? {{24{lane_byte[7]}}, lane_byte} : rdata_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (trap) begin
          err_d = 1'b1;
        end else if (mem_op) begin
          state_d = StReq;
          req_d   = 1'b1;
          we_d    = MEM_MemWrite;
          addr_d  = {MEM_ALU_out[31:2], 2'b00};
          wdata_d = MEM_WriteData;
          cnt_d   = 8'd0;
        end
      end
      StReq: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (mem_ack) begin
          rdata_d = mem_rdata;
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          rdata_d = 32'd0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_regwrite_d = 1'b0;
    wb_waddr_d    = 5'd0;
    wb_memtoreg_d = 2'd0;
    wb_alu_d      = 32'd0;
    wb_memdata_d  = 32'd0;
    wb_pc4_d      = 32'd0;
    if (!stall) begin
      wb_regwrite_d = MEM_RegWrite && !trap;
      wb_waddr_d    = MEM_WriteAddr;
      wb_memtoreg_d = MEM_MemtoReg;
      wb_alu_d      = MEM_ALU_out;
      wb_pc4_d      = MEM_PC_Plus_4;
      wb_memdata_d  = (is_load && !trap) ? load_data : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      rdata_q       <= 32'd0;
      err_q         <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_waddr_q    <= 5'd0;
      wb_memtoreg_q <= 2'd0;
      wb_alu_q      <= 32'd0;
      wb_memdata_q  <= 32'd0;
      wb_pc4_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_waddr_q    <= wb_waddr_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      wb_alu_q      <= wb_alu_d;
      wb_memdata_q  <= wb_memdata_d;
      wb_pc4_q      <= wb_pc4_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_err      = err_q;
  assign WB_RegWrite  = wb_regwrite_q;
  assign WB_WriteAddr = wb_waddr_q;
  assign WB_MemtoReg  = wb_memtoreg_q;
  assign WB_ALU_out   = wb_alu_q;
  assign WB_MemData   = wb_memdata_q;
  assign WB_PC_Plus_4 = wb_pc4_q;

endmodule
